// File: rtl/fpu_result_stage.sv
// ============================================================================
// Module      : fpu_result_stage
// Description : FP result output stage. Selects the add/mul result, lets the
//               exception path override it, classifies the value, queues it in
//               a small valid/ready FIFO, and keeps sticky status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_result_stage #(
  parameter int DEPTH     = 2,     // FIFO entries, power of 2, >= 2
  parameter bit CANON_NAN = 1'b1   // map all-ones exception results to qNaN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] add_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] addOutException,
  input  logic [31:0] multoutexception,
  input  logic        exceptionFlagADD,
  input  logic        exceptionFlagMUL,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_status,
  input  logic        sticky_clear,
  output logic [2:0]  sticky_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   ALL_ONES   = 32'hFFFF_FFFF;
  localparam logic [31:0]   QNAN       = 32'h7FC0_0000;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] mem_result [DEPTH];
  logic [2:0]  mem_status [DEPTH];

  logic        enq;
  logic        deq;
  logic        sel_exc;
  logic [31:0] sel_res;
  logic [2:0]  sel_status;

  // Handshake flags; in_ready looks only at count so a full FIFO never
  // accepts, even when the head leaves in the same cycle.
  always_comb begin
    in_ready  = (count != FULL_COUNT);
    out_valid = (count != '0);
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
  end

  // Result selection, NaN canonicalisation and classification of the
  // incoming operation.
  always_comb begin
    sel_exc = in_op ? exceptionFlagMUL : exceptionFlagADD;
    if (sel_exc) begin
      sel_res = in_op ? multoutexception : addOutException;
    end else begin
      sel_res = in_op ? mul_result : add_result;
    end
    if (CANON_NAN && sel_exc && (sel_res == ALL_ONES)) begin
      sel_res = QNAN;
    end
    sel_status[2] = sel_exc;
    sel_status[1] = !sel_exc && (sel_res[30:23] == 8'hFF) && (sel_res[22:0] == '0);
    sel_status[0] = (sel_res[30:0] == '0);
  end

  // Head entry; gated by out_valid so reset and empty states read as zero.
  always_comb begin
    out_result = out_valid ? mem_result[rd_ptr] : '0;
    out_status = out_valid ? mem_status[rd_ptr] : '0;
  end

  // Storage array; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_result[wr_ptr] <= sel_res;
      mem_status[wr_ptr] <= sel_status;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status accumulates the status of each dequeued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (deq) begin
      sticky_flags <= sticky_clear ? out_status : (sticky_flags | out_status);
    end else if (sticky_clear) begin
      sticky_flags <= '0;
    end
  end

endmodule

`default_nettype wire
